ifft_8points: RTL
=================

# ifft_8points

Fixed-point 8-point inverse FFT, the counterpart of the forward 8-point FFT in the same datapath. It accepts one complex frequency-domain frame of 8 bins in parallel on a start strobe. It computes the exact IDFT, including the 1/8 scale, with an iterative radix-2 butterfly engine, and presents 8 complex time-domain samples in parallel with a one-cycle done pulse. Port shapes and handshake mirror the forward transform so that FFT output can feed this block directly for round-trip checks.

## Interface
- `NUM_POINTS`, 8: transform size; only 8 is supported.
- `SIZE_DATA`, 32: sample width; signed two's complement Q16.16, for both real and imaginary parts.
- `i_clk` in 1: the block's single clock; all logic is on the rising edge.
- `i_rst_n` in 1: reset, synchronous and active-low.
- `i_start` in 1: start strobe; sampled only in IDLE.
- `i_data_re` in `[NUM_POINTS-1:0][SIZE_DATA-1:0]`: real parts of bins X[0..7].
- `i_data_im` in `[NUM_POINTS-1:0][SIZE_DATA-1:0]`: imaginary parts of bins X[0..7].
- `o_data_re` out `[NUM_POINTS-1:0][SIZE_DATA-1:0]`: real parts of x[0..7]; registered.
- `o_data_im` out `[NUM_POINTS-1:0][SIZE_DATA-1:0]`: imaginary parts of x[0..7]; registered.
- `o_done` out 1: one-cycle pulse when `o_data_*` has been updated.

## Operation
- Algorithm: radix-2 decimation-in-time.
  - Bins are loaded in bit-reversed order.
  - 3 stages of 4 butterflies each.
  - Twiddle is W = e^{+j2πk/8}, the conjugate of the forward FFT twiddle. Per stage s, k = (butterfly index mod 2^s)·2^(2−s).
- Butterfly with inputs a, b and twiddle W:
  - t = W·b
  - a' = (a + t) >>> 1
  - b' = (a − t) >>> 1
  - The per-stage halving gives the total 1/8 scale, so no final divide is needed.
- Arithmetic:
  - Twiddles are 16-bit signed Q2.14: cos45 = 11585; 1.0 = 16384.
  - Products are full width, SIZE_DATA+16 bits, arithmetic-shifted right by 14 and truncated (floor).
  - Sums are formed in SIZE_DATA+1 bits before the >>>1, so intermediate sums cannot overflow.
  - The final result is truncated back to SIZE_DATA bits.
- FSM:
  - IDLE: if `i_start`, capture `i_data_*` bit-reversed into the working registers, clear stage and butterfly counters, go to CALC.
  - CALC: one butterfly per cycle, with the result written back to the working registers. The butterfly counter runs 0..3 and the stage counter 0..2. After stage 2, butterfly 3, go to DONE.
  - DONE: copy the working registers to `o_data_*`, assert `o_done`, go to IDLE.
- `i_start` is ignored in CALC and DONE; there is no queueing.
- `o_data_*` holds the last result until the next DONE.

## Timing
- Reset values: `o_done` = 0, all `o_data_*` = 0, working registers = 0, counters = 0, state = IDLE.
- Latency: capture edge E0, butterflies on E1..E12, output load and `o_done` = 1 after E13. That is 13 cycles from capture to done.
- `o_done` is high for exactly one cycle.
- Throughput: if `i_start` is held high, a new frame is captured on the edge following the done cycle, i.e. one frame every 14 cycles.
- Reset asserted in any state takes effect on the next edge. It:
  - aborts the frame,
  - clears the outputs,
  - suppresses `o_done`.
- A start in the first cycle after reset deassertion is accepted.

## Structure
- Package `fft_pkg`, shared with the forward FFT, holds:
  - the twiddle constants (cos and sin for k = 0..3, Q2.14) and `TW_FRAC` = 14;
  - the bit-reverse index table for N = 8;
  - the FSM state enum (IDLE, CALC, DONE).
- Sub-module `ifft_butterfly` is combinational. It takes a, b, twiddle (re/im) and returns a', b' with the width rules above. It is instantiated once and is time-multiplexed by the butterfly/stage counters, which select operand indices.

## Test plan
- All bins X[k] = 8.0 (re = 0x0008_0000, im = 0) → x[0].re = 0x0008_0000, all other outputs 0. `o_done` rises exactly 13 cycles after the capture edge.
- X[0] = 8.0 only → every x[n].re = 0x0001_0000, every im = 0.
- X[1] = 8.0 only → x[n] = e^{j2πn/8}:
  - x[2].im = 0x0001_0000
  - x[4].re = 0xFFFF_0000
  - x[1].re and x[1].im = 46340 ± 2 LSB
- Round trip: random Q16.16 samples in ±100.0 → forward FFT → this block. Outputs match the originals within ±8 LSB.
- Reset mid-CALC: assert `i_rst_n` = 0 on butterfly 5 → `o_done` stays 0 and outputs read 0. A start after release gives the correct result for the new frame.
- Start while busy: pulse `i_start` with different data at E5 → ignored; the result matches the first frame. `i_start` held high → `o_done` pulses every 14 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point radix-2 FFT/IFFT datapaths:
// Q2.14 twiddles, bit-reverse table, FSM states and butterfly index math.
package fft_pkg;

  localparam int TW_W    = 16;
  localparam int TW_FRAC = 14;

  localparam logic signed [TW_W-1:0] TW_ONE = 16'sd16384;
  localparam logic signed [TW_W-1:0] TW_C45 = 16'sd11585;

  // cos and sin of 2*pi*k/8 for k = 0..3; the inverse uses +sin, the forward -sin
  localparam logic [3:0][TW_W-1:0] TW_COS = {-TW_C45, 16'sd0, TW_C45, TW_ONE};
  localparam logic [3:0][TW_W-1:0] TW_SIN = {TW_C45, TW_ONE, TW_C45, 16'sd0};

  localparam logic [7:0][2:0] BIT_REV = {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] top_index(input logic [1:0] stage, input logic [1:0] bfly);
    case (stage)
      2'd0:    return {bfly, 1'b0};
      2'd1:    return {bfly[1], 1'b0, bfly[0]};
      default: return {1'b0, bfly};
    endcase
  endfunction

  function automatic logic [2:0] bot_index(input logic [1:0] stage, input logic [1:0] bfly);
    return top_index(stage, bfly) | (3'd1 << stage);
  endfunction

  // k = (bfly mod 2^stage) * 2^(2-stage)
  function automatic logic [1:0] twiddle_index(input logic [1:0] stage, input logic [1:0] bfly);
    case (stage)
      2'd0:    return 2'd0;
      2'd1:    return {bfly[0], 1'b0};
      default: return bfly;
    endcase
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with per-stage halving:
// a' = (a + W*b) >>> 1, b' = (a - W*b) >>> 1.
module ifft_butterfly
  import fft_pkg::*;
#(
  parameter int SIZE_DATA = 32
) (
  input  logic signed [SIZE_DATA-1:0] a_re,
  input  logic signed [SIZE_DATA-1:0] a_im,
  input  logic signed [SIZE_DATA-1:0] b_re,
  input  logic signed [SIZE_DATA-1:0] b_im,
  input  logic signed [TW_W-1:0]      w_re,
  input  logic signed [TW_W-1:0]      w_im,
  output logic signed [SIZE_DATA-1:0] ya_re,
  output logic signed [SIZE_DATA-1:0] ya_im,
  output logic signed [SIZE_DATA-1:0] yb_re,
  output logic signed [SIZE_DATA-1:0] yb_im
);

  localparam int PW = SIZE_DATA + TW_W;

  logic signed [PW-1:0]      p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]        acc_re, acc_im;
  logic signed [SIZE_DATA-1:0] t_re, t_im;
  logic signed [SIZE_DATA:0] sa_re, sa_im, sd_re, sd_im;

  assign p_rr = PW'(b_re) * PW'(w_re);
  assign p_ii = PW'(b_im) * PW'(w_im);
  assign p_ri = PW'(b_re) * PW'(w_im);
  assign p_ir = PW'(b_im) * PW'(w_re);

  // Full-precision complex product, then a single floor shift back to Q16.16
  assign acc_re = (PW+1)'(p_rr) - (PW+1)'(p_ii);
  assign acc_im = (PW+1)'(p_ri) + (PW+1)'(p_ir);
  assign t_re   = SIZE_DATA'(acc_re >>> TW_FRAC);
  assign t_im   = SIZE_DATA'(acc_im >>> TW_FRAC);

  assign sa_re = (SIZE_DATA+1)'(a_re) + (SIZE_DATA+1)'(t_re);
  assign sa_im = (SIZE_DATA+1)'(a_im) + (SIZE_DATA+1)'(t_im);
  assign sd_re = (SIZE_DATA+1)'(a_re) - (SIZE_DATA+1)'(t_re);
  assign sd_im = (SIZE_DATA+1)'(a_im) - (SIZE_DATA+1)'(t_im);

  assign ya_re = SIZE_DATA'(sa_re >>> 1);
  assign ya_im = SIZE_DATA'(sa_im >>> 1);
  assign yb_re = SIZE_DATA'(sd_re >>> 1);
  assign yb_im = SIZE_DATA'(sd_im >>> 1);

endmodule

// File: rtl/ifft_8points.sv
// 8-point fixed-point inverse FFT: bit-reversed load, then 12 butterflies
// on one shared butterfly unit, then a registered parallel output with done pulse.
module ifft_8points
  import fft_pkg::*;
#(
  parameter int NUM_POINTS = 8,
  parameter int SIZE_DATA  = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_start,
  input  logic [NUM_POINTS-1:0][SIZE_DATA-1:0]  i_data_re,
  input  logic [NUM_POINTS-1:0][SIZE_DATA-1:0]  i_data_im,
  output logic [NUM_POINTS-1:0][SIZE_DATA-1:0]  o_data_re,
  output logic [NUM_POINTS-1:0][SIZE_DATA-1:0]  o_data_im,
  output logic                                  o_done
);

  state_t                      state_reg;
  logic [1:0]                  stage_reg, bfly_reg;
  logic signed [SIZE_DATA-1:0] work_re_reg [NUM_POINTS];
  logic signed [SIZE_DATA-1:0] work_im_reg [NUM_POINTS];

  logic [SIZE_DATA-1:0]        load_re [NUM_POINTS];
  logic [SIZE_DATA-1:0]        load_im [NUM_POINTS];
  logic [2:0]                  idx_top, idx_bot;
  logic [1:0]                  tw_k;
  logic signed [TW_W-1:0]      w_re, w_im;
  logic signed [SIZE_DATA-1:0] ya_re, ya_im, yb_re, yb_im;

  for (genvar gi = 0; gi < NUM_POINTS; gi++) begin : g_brev
    assign load_re[gi] = i_data_re[BIT_REV[gi]];
    assign load_im[gi] = i_data_im[BIT_REV[gi]];
  end

  // Counters pick which pair of working registers the shared butterfly serves
  assign idx_top = top_index(stage_reg, bfly_reg);
  assign idx_bot = bot_index(stage_reg, bfly_reg);
  assign tw_k    = twiddle_index(stage_reg, bfly_reg);
  assign w_re    = TW_COS[tw_k];
  assign w_im    = TW_SIN[tw_k];

  ifft_butterfly #(.SIZE_DATA(SIZE_DATA)) u_bfly (
    .a_re  (work_re_reg[idx_top]),
    .a_im  (work_im_reg[idx_top]),
    .b_re  (work_re_reg[idx_bot]),
    .b_im  (work_im_reg[idx_bot]),
    .w_re  (w_re),
    .w_im  (w_im),
    .ya_re (ya_re),
    .ya_im (ya_im),
    .yb_re (yb_re),
    .yb_im (yb_im)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      stage_reg <= 2'd0;
      bfly_reg  <= 2'd0;
      o_done    <= 1'b0;
      o_data_re <= '0;
      o_data_im <= '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
        work_re_reg[i] <= '0;
        work_im_reg[i] <= '0;
      end
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
              work_re_reg[i] <= load_re[i];
              work_im_reg[i] <= load_im[i];
            end
            stage_reg <= 2'd0;
            bfly_reg  <= 2'd0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          work_re_reg[idx_top] <= ya_re;
          work_im_reg[idx_top] <= ya_im;
          work_re_reg[idx_bot] <= yb_re;
          work_im_reg[idx_bot] <= yb_im;
          if (bfly_reg == 2'd3) begin
            bfly_reg <= 2'd0;
            if (stage_reg == 2'd2) begin
              state_reg <= DONE;
            end else begin
              stage_reg <= stage_reg + 2'd1;
            end
          end else begin
            bfly_reg <= bfly_reg + 2'd1;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_POINTS; i++) begin
            o_data_re[i] <= work_re_reg[i];
            o_data_im[i] <= work_im_reg[i];
          end
          o_done    <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
